// File: rtl/mem_access_unit.sv
// Memory access unit: turns a valid/ready request stream into timed accesses
// on a simple memory port that has no enable (mode=0 writes every cycle).
// Misaligned requests (address not a multiple of 8) are answered with an
// error response and never touch the memory.
module mem_access_unit #(
    parameter int READ_LAT  = 1,
    parameter int WRITE_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqMode,
    input  logic [63:0] reqAddr,
    input  logic [63:0] reqData,
    output logic        respValid,
    input  logic        respReady,
    output logic [63:0] respData,
    output logic        respErr,
    output logic        mode,
    output logic [63:0] address,
    output logic [63:0] dataIn,
    input  logic [63:0] dataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Dwell counter reload values: the state advances once the counter hits 0.
    localparam logic [3:0] WRITE_LOAD = 4'(WRITE_CYC - 1);
    localparam logic [3:0] READ_LOAD  = 4'(READ_LAT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        mode_r;
    logic        mode_s;
    logic [63:0] address_r;
    logic [63:0] address_s;
    logic [63:0] data_in_r;
    logic [63:0] data_in_s;
    logic        resp_valid_r;
    logic        resp_valid_s;
    logic [63:0] resp_data_r;
    logic [63:0] resp_data_s;
    logic        resp_err_r;
    logic        resp_err_s;

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        mode_s       = mode_r;
        address_s    = address_r;
        data_in_s    = data_in_r;
        resp_valid_s = resp_valid_r;
        resp_data_s  = resp_data_r;
        resp_err_s   = resp_err_r;
        case (state_r)
            IDLE: begin
                if (reqValid) begin
                    if (reqAddr[2:0] != 3'b000) begin
                        // Misaligned: answer at once, memory port untouched.
                        state_s      = RESP;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                        resp_data_s  = 64'd0;
                    end else if (reqMode == 1'b0) begin
                        state_s   = WRITE;
                        mode_s    = 1'b0;
                        address_s = reqAddr;
                        data_in_s = reqData;
                        cnt_s     = WRITE_LOAD;
                    end else begin
                        state_s   = READ;
                        mode_s    = 1'b1;
                        address_s = reqAddr;
                        cnt_s     = READ_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (cnt_r == 4'd0) begin
                    // Leaving WRITE must put the port back in read mode so
                    // the memory stops being written.
                    state_s      = RESP;
                    mode_s       = 1'b1;
                    resp_valid_s = 1'b1;
                    resp_err_s   = 1'b0;
                    resp_data_s  = 64'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            READ: begin
                if (cnt_r == 4'd0) begin
                    state_s      = RESP;
                    resp_valid_s = 1'b1;
                    resp_err_s   = 1'b0;
                    resp_data_s  = dataOut;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (respReady) begin
                    state_s      = IDLE;
                    resp_valid_s = 1'b0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s      = IDLE;
                mode_s       = 1'b1;
                resp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            mode_r       <= 1'b1;
            address_r    <= 64'd0;
            data_in_r    <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 64'd0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mode_r       <= mode_s;
            address_r    <= address_s;
            data_in_r    <= data_in_s;
            resp_valid_r <= resp_valid_s;
            resp_data_r  <= resp_data_s;
            resp_err_r   <= resp_err_s;
        end
    end

    // Ready is gated by the live reset so it is low for the whole reset
    // window and rises in the very first cycle after reset drops.
    assign reqReady  = (state_r == IDLE) && !reset;
    assign respValid = resp_valid_r;
    assign respData  = resp_data_r;
    assign respErr   = resp_err_r;
    assign mode      = mode_r;
    assign address   = address_r;
    assign dataIn    = data_in_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (default timing, and READ_LAT=3 /
// WRITE_CYC=4) each with a private memory, checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid  [2];
    logic        req_mode   [2];
    logic        resp_ready [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_data   [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_err   [2];
    logic        mode       [2];
    logic [63:0] resp_data  [2];
    logic [63:0] address    [2];
    logic [63:0] data_in    [2];
    logic [63:0] data_out   [2];
    logic [63:0] mem        [2][64];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            mem_access_unit #(
                .READ_LAT (g == 0 ? 1 : 3),
                .WRITE_CYC(g == 0 ? 1 : 4)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .reqValid (req_valid[g]),
                .reqReady (req_ready[g]),
                .reqMode  (req_mode[g]),
                .reqAddr  (req_addr[g]),
                .reqData  (req_data[g]),
                .respValid(resp_valid[g]),
                .respReady(resp_ready[g]),
                .respData (resp_data[g]),
                .respErr  (resp_err[g]),
                .mode     (mode[g]),
                .address  (address[g]),
                .dataIn   (data_in[g]),
                .dataOut  (data_out[g])
            );
            assign data_out[g] = mem[g][address[g][8:3]];
        end
    endgenerate

    // ---------------- reference model (transaction level) ----------------
    int          cyc   = 0;    // index of the last rising edge
    int          total = 0;
    int          bad   = 0;
    bit          armed = 1'b0; // set once a reset edge has been seen
    bit          rst_edge;
    bit          m_busy [2];   // request accepted, response not yet consumed
    bit          m_wr   [2];
    bit          m_mis  [2];
    int          m_t    [2];   // accepting edge
    int          m_rf   [2];   // first edge after which respValid is high
    logic [63:0] m_rdata[2];
    logic [63:0] m_addr [2];   // last address put on the memory port
    logic [63:0] m_din  [2];   // last write data put on the memory port
    logic [63:0] m_mem  [2][64];
    bit          pend_we [2];
    logic [5:0]  pend_idx[2];
    logic [63:0] pend_d  [2];

    function automatic int rl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int wc(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, k, cyc, act, exp);
        end
    endtask

    // Advance model and memories across one rising edge (inputs are stable).
    task automatic model_step();
        cyc++;
        rst_edge = (reset === 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (pend_we[k]) mem[k][pend_idx[k]] = pend_d[k];
            if (rst_edge) begin
                m_busy[k] = 1'b0;
                m_addr[k] = 64'd0;
                m_din[k]  = 64'd0;
            end else if (m_busy[k]) begin
                if (cyc - 1 >= m_rf[k] && resp_ready[k] === 1'b1) m_busy[k] = 1'b0;
            end else if (req_valid[k] === 1'b1) begin
                m_busy[k] = 1'b1;
                m_t[k]    = cyc;
                m_mis[k]  = (req_addr[k][2:0] != 3'd0);
                m_wr[k]   = (req_mode[k] == 1'b0);
                m_rdata[k] = 64'd0;
                if (m_mis[k]) begin
                    m_rf[k] = cyc;
                end else if (m_wr[k]) begin
                    m_rf[k]   = cyc + wc(k);
                    m_addr[k] = req_addr[k];
                    m_din[k]  = req_data[k];
                    m_mem[k][req_addr[k][8:3]] = req_data[k];
                end else begin
                    m_rf[k]    = cyc + rl(k);
                    m_addr[k]  = req_addr[k];
                    m_rdata[k] = m_mem[k][req_addr[k][8:3]];
                end
            end
        end
        if (rst_edge) armed = 1'b1;
    endtask

    // Compare every DUT output against the model; capture memory writes.
    task automatic compare();
        logic em;
        logic erv;
        for (int k = 0; k < 2; k++) begin
            if (armed) begin
                em = 1'b1;
                if (m_busy[k] && m_wr[k] && !m_mis[k] && cyc >= m_t[k] && cyc <= m_t[k] + wc(k) - 1)
                    em = 1'b0;
                erv = m_busy[k] && (cyc >= m_rf[k]);
                chk("mode", k, mode[k], em);
                chk("respValid", k, resp_valid[k], erv);
                chk("reqReady", k, req_ready[k], !reset && !m_busy[k]);
                chk("address", k, address[k], m_addr[k]);
                chk("dataIn", k, data_in[k], m_din[k]);
                if (erv) begin
                    chk("respData", k, resp_data[k], m_rdata[k]);
                    chk("respErr", k, resp_err[k], m_mis[k]);
                end
                if (rst_edge) begin
                    chk("rst_respData", k, resp_data[k], 64'd0);
                    chk("rst_respErr", k, resp_err[k], 64'd0);
                end
            end
            pend_we[k]  = (mode[k] === 1'b0);
            pend_idx[k] = address[k][8:3];
            pend_d[k]   = data_in[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // One directed transaction on instance k; returns latency (edges after
    // the accepting edge until respValid is seen), data, error and the number
    // of cycles mode was 0. Holds respReady low for 'hold' extra cycles.
    task automatic xact(input int k, input bit wr, input logic [63:0] a, input logic [63:0] d,
                        input int hold, output int lat, output logic [63:0] rd,
                        output logic er, output int m0);
        int n;
        req_valid[k] = 1'b1;
        req_mode[k]  = !wr;
        req_addr[k]  = a;
        req_data[k]  = d;
        resp_ready[k] = 1'b0;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout dut%0d: got no reqReady want reqReady", k);
        end
        tick();
        // Inputs after accept must be ignored: scramble them.
        req_valid[k] = 1'b0;
        req_mode[k]  = 1'($urandom_range(0, 1));
        req_addr[k]  = {$urandom(), $urandom()};
        req_data[k]  = {$urandom(), $urandom()};
        lat = 0;
        m0  = 0;
        while (resp_valid[k] !== 1'b1 && lat < 50) begin
            if (mode[k] === 1'b0) m0++;
            tick();
            lat++;
        end
        if (lat >= 50) begin
            total++; bad++;
            $display("FAIL resp_timeout dut%0d: got no respValid want respValid", k);
        end
        rd = resp_data[k];
        er = resp_err[k];
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", k, resp_valid[k], 64'd1);
            chk("hold_ready", k, req_ready[k], 64'd0);
        end
        resp_ready[k] = 1'b1;
        tick();
        resp_ready[k] = 1'b0;
        chk("resume_ready", k, req_ready[k], 64'd1);
    endtask

    int          lat;
    int          m0;
    logic [63:0] rd;
    logic        er;

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_mode[k]  = 1'b1;
            req_addr[k]  = 64'd0;
            req_data[k]  = 64'd0;
            resp_ready[k] = 1'b0;
            m_busy[k] = 1'b0;
            pend_we[k] = 1'b0;
            for (int i = 0; i < 64; i++) begin
                mem[k][i]   = {$urandom(), $urandom()};
                m_mem[k][i] = mem[k][i];
            end
        end
        mem[1][8]   = 64'hDEAD_BEEF;
        m_mem[1][8] = 64'hDEAD_BEEF;

        // Reset state.
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, req_ready[k], 64'd0);
            chk("rst_mode", k, mode[k], 64'd1);
            chk("rst_address", k, address[k], 64'd0);
        end
        reset = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) chk("ready_after_rst", k, req_ready[k], 64'd1);

        // Write 2017 to address 0, then read it back (default timing).
        xact(0, 1'b1, 64'h0, 64'd2017, 0, lat, rd, er, m0);
        chk("wr_mode0_cycles", 0, 64'(m0), 64'd1);
        chk("wr_lat", 0, 64'(lat), 64'd1);
        chk("wr_err", 0, er, 64'd0);
        xact(0, 1'b0, 64'h0, 64'd0, 0, lat, rd, er, m0);
        chk("rd_data_2017", 0, rd, 64'h7E1);
        chk("rd_err", 0, er, 64'd0);
        chk("rd_lat", 0, 64'(lat), 64'd1);

        // READ_LAT=3: respValid in the 4th cycle after accept, i.e. three
        // edges after the accepting edge.
        xact(1, 1'b0, 64'h40, 64'd0, 0, lat, rd, er, m0);
        chk("rd3_lat", 1, 64'(lat), 64'd3);
        chk("rd3_data", 1, rd, 64'hDEAD_BEEF);

        // Misaligned write to 0x5: immediate error, memory untouched.
        xact(0, 1'b1, 64'h5, 64'h1234, 0, lat, rd, er, m0);
        chk("mis_err", 0, er, 64'd1);
        chk("mis_data", 0, rd, 64'd0);
        chk("mis_lat", 0, 64'(lat), 64'd0);
        chk("mis_mode0_cycles", 0, 64'(m0), 64'd0);

        // Backpressure for 5 cycles; word 0 must still hold 2017.
        xact(0, 1'b0, 64'h0, 64'd0, 5, lat, rd, er, m0);
        chk("bp_data", 0, rd, 64'd2017);

        // Reset on the first WRITE cycle of the WRITE_CYC=4 instance.
        req_valid[1] = 1'b1;
        req_mode[1]  = 1'b0;
        req_addr[1]  = 64'h80;
        req_data[1]  = 64'h0123_4567_89AB_CDEF;
        tick();
        req_valid[1] = 1'b0;
        chk("wr4_first_mode", 1, mode[1], 64'd0);
        reset = 1'b1;
        tick();
        chk("trunc_mode", 1, mode[1], 64'd1);
        chk("trunc_valid", 1, resp_valid[1], 64'd0);
        chk("trunc_address", 1, address[1], 64'd0);
        chk("trunc_dataIn", 1, data_in[1], 64'd0);
        chk("trunc_ready", 1, req_ready[1], 64'd0);
        reset = 1'b0;
        tick();
        chk("trunc_ready_after", 1, req_ready[1], 64'd1);

        // Randomized traffic, including occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k]  = 1'($urandom_range(0, 1));
                req_mode[k]   = 1'($urandom_range(0, 1));
                req_addr[k]   = {($urandom_range(0, 7) == 0) ? 55'($urandom()) : 55'd0,
                                 6'($urandom_range(0, 63)),
                                 ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0};
                req_data[k]   = {$urandom(), $urandom()};
                resp_ready[k] = ($urandom_range(0, 9) < 6);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter READ_LAT, default 1, SHALL give the cycles address is held before dataOut is sampled; legal range is 1..15.
REQ-002 Parameter WRITE_CYC, default 1, SHALL give the cycles mode=0 is held per write; legal range is 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 reqValid  input  1  SHALL mark a valid request from the requester.
REQ-006 reqReady  output  1  SHALL mark that the unit accepts a request this cycle.
REQ-007 reqMode  input  1  SHALL select the request type: 0 = write, 1 = read (same encoding as memory mode).
REQ-008 reqAddr  input  64  SHALL carry the byte address.
REQ-009 reqData  input  64  SHALL carry the write data.
REQ-010 respValid  output  1  SHALL mark a completed request.
REQ-011 respReady  input  1  SHALL mark that the requester consumes the response.
REQ-012 respData  output  64  SHALL carry the read data; it is 0 for writes and errors.
REQ-013 respErr  output  1  SHALL flag a misaligned request.
REQ-014 mode  output  1  SHALL drive the memory mode: 0 = write, 1 = read.
REQ-015 address  output  64  SHALL drive the memory address.
REQ-016 dataIn  output  64  SHALL drive the memory write data.
REQ-017 dataOut  input  64  SHALL carry the memory read data, combinational from address.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, WRITE, READ, RESP.
REQ-019 mode SHALL be 1 in every state except WRITE, because the memory has no enable and mode=0 always writes.
REQ-020 reqReady SHALL be 1 only in IDLE and never while reset is high; a request is accepted at an edge where reqValid and reqReady are both 1.
REQ-021 On accept, reqAddr, reqData and reqMode SHALL be registered; requester inputs after accept SHALL be ignored.
REQ-022 A request with reqAddr[2:0] != 0 SHALL go IDLE->RESP with respErr=1 and respData=0, with no memory access; respValid is 1 in the cycle after accept.
REQ-023 An aligned write accepted at edge N SHALL drive mode=0, address and dataIn for cycles N+1 .. N+WRITE_CYC, then enter RESP with respErr=0 and respData=0.
REQ-024 An aligned read accepted at edge N SHALL drive mode=1 and address from cycle N+1.
REQ-025 The read SHALL register dataOut into respData at the end of cycle N+READ_LAT, then enter RESP.
REQ-026 The WRITE and READ dwell SHALL use one 4-bit down-counter loaded with WRITE_CYC-1 or READ_LAT-1; the state advances when the counter is 0.
REQ-027 In RESP, respValid SHALL be 1 and respData/respErr SHALL hold stable until respReady=1.
REQ-028 When respReady=1 in RESP, the FSM SHALL go to IDLE next cycle; it SHALL NOT accept in that same cycle, so the minimum spacing is one idle cycle.
REQ-029 respReady SHALL be ignored outside RESP.
REQ-030 reqValid SHALL be ignored outside IDLE.
REQ-031 address SHALL hold its last value in IDLE and RESP.
REQ-032 dataIn SHALL hold its last value in IDLE and RESP.

Reset
REQ-033 While reset=1, the unit SHALL drive state=IDLE, mode=1, address=0, dataIn=0, reqReady=0, respValid=0, respData=0, respErr=0 and counter=0.
REQ-034 A reset asserted during WRITE SHALL drive mode=1 from the next cycle, truncating the write.
REQ-035 A reset asserted during READ or RESP SHALL discard the pending response.
REQ-036 reqReady SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 Write then read: write addr=0, data=2017, then read addr=0 (defaults) -> mode=0 for exactly 1 cycle; read respData=2017 (0x7E1) with respErr=0.
REQ-038 READ_LAT=3, read addr=0x40 preloaded with 0xDEADBEEF -> respValid 4 cycles after accept; respData=0xDEADBEEF.
REQ-039 Misaligned write addr=0x5 -> respErr=1 next cycle, and mode never 0, so memory is unchanged.
REQ-040 Backpressure: hold respReady=0 for 5 cycles -> respValid and respData stable and reqReady=0 throughout; accept resumes 1 cycle after respReady=1.
REQ-041 Reset on the first WRITE cycle with WRITE_CYC=4 -> mode=1 and all outputs at reset values on the next cycle; reqReady=1 after reset drops.
